pc_sequencer: RTL and testbench

//   Fetch/PC controller for the single-cycle CPU: owns the PC register, drives the

---
 rtl/pc_sequencer_pkg.sv | 24 ++
 rtl/pc_sequencer_next_pc_calc.sv | 39 +++
 rtl/pc_sequencer.sv | 120 ++++++++++++
 tb/tb_pc_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch/PC controller: FSM states, instruction
// field widths, PC step and the branch-offset helper.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned TARGET_W = 26;
  localparam int unsigned IMM_W    = 16;
  localparam int unsigned CNT_W    = 8;

  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  // Sign-extended word offset of a beq-type immediate.
  function automatic logic [XLEN-1:0] branch_offset(input logic [IMM_W-1:0] imm);
    return {{(XLEN-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_sequencer_next_pc_calc.sv
// Combinational next-PC selection: jr > j > taken beq > pc+4, plus a flag
// for targets that are not word aligned.
module pc_sequencer_next_pc_calc
  import pc_sequencer_pkg::*;
(
  input  logic [XLEN-1:0]     i_pc,
  input  logic [TARGET_W-1:0] i_target,
  input  logic                i_branch,
  input  logic                i_zero,
  input  logic                i_jump,
  input  logic                i_jump_reg,
  input  logic [XLEN-1:0]     i_reg31,
  output logic [XLEN-1:0]     o_next_pc_c,
  output logic                o_misalign_c
);

  logic [XLEN-1:0] w_pc4;
  logic [XLEN-1:0] w_jump;
  logic [XLEN-1:0] w_branch;

  assign w_pc4    = i_pc + PC_STEP;
  assign w_jump   = {w_pc4[XLEN-1:XLEN-4], i_target, 2'b00};
  assign w_branch = w_pc4 + branch_offset(i_target[IMM_W-1:0]);

  always_comb begin
    o_next_pc_c = w_pc4;
    if (i_jump_reg) begin
      o_next_pc_c = i_reg31;
    end else if (i_jump) begin
      o_next_pc_c = w_jump;
    end else if (i_branch && i_zero) begin
      o_next_pc_c = w_branch;
    end
  end

  // Only the jr path can produce a misaligned target.
  assign o_misalign_c = |o_next_pc_c[1:0];

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/PC controller: owns the PC, runs the imem request/ack handshake with a
// timeout, holds the current instruction and advances the PC on exec_done.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Inst,
  output logic        inst_valid,
  input  logic        exec_done,
  input  logic        Branch,
  input  logic        Zero,
  input  logic        Jump,
  input  logic        JumpReg,
  input  logic [31:0] reg31,
  output logic [31:0] pc,
  output logic        fetch_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_inst;
  logic [CNT_W-1:0] r_cnt;
  logic            r_req;
  logic            r_valid;
  logic            r_err;

  logic [XLEN-1:0] w_next_pc;
  logic            w_misalign;

  pc_sequencer_next_pc_calc u_next_pc (
    .i_pc         (r_pc),
    .i_target     (r_inst[TARGET_W-1:0]),
    .i_branch     (Branch),
    .i_zero       (Zero),
    .i_jump       (Jump),
    .i_jump_reg   (JumpReg),
    .i_reg31      (reg31),
    .o_next_pc_c  (w_next_pc),
    .o_misalign_c (w_misalign)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_inst  <= '0;
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_FETCH;
          r_req   <= 1'b1;
          r_cnt   <= '0;
        end
        ST_FETCH: begin
          // An ack in the last allowed cycle still completes the fetch.
          if (imem_ack) begin
            r_inst  <= imem_rdata;
            r_req   <= 1'b0;
            r_valid <= 1'b1;
            r_cnt   <= '0;
            r_state <= ST_EXEC;
          end else if (r_cnt == CNT_LAST) begin
            r_req   <= 1'b0;
            r_err   <= 1'b1;
            r_state <= ST_ERROR;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_EXEC: begin
          if (exec_done) begin
            r_valid <= 1'b0;
            if (w_misalign) begin
              r_err   <= 1'b1;
              r_state <= ST_ERROR;
            end else begin
              r_pc    <= w_next_pc;
              r_req   <= 1'b1;
              r_cnt   <= '0;
              r_state <= ST_FETCH;
            end
          end
        end
        ST_ERROR: begin
          r_req   <= 1'b0;
          r_valid <= 1'b0;
          r_err   <= 1'b1;
        end
        default: begin
          r_req   <= 1'b0;
          r_valid <= 1'b0;
          r_err   <= 1'b1;
          r_state <= ST_ERROR;
        end
      endcase
    end
  end

  assign imem_req   = r_req;
  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign Inst       = r_inst;
  assign inst_valid = r_valid;
  assign fetch_err  = r_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized bench for pc_sequencer against an arithmetic
// next-PC reference model.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          TMO    = 15;

  logic        Clock;
  logic        Reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] Inst;
  logic        inst_valid;
  logic        exec_done;
  logic        Branch;
  logic        Zero;
  logic        Jump;
  logic        JumpReg;
  logic [31:0] reg31;
  logic [31:0] pc;
  logic        fetch_err;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic        err_seen;

  pc_sequencer #(.RESET_PC(RST_PC), .TIMEOUT(TMO)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .Inst       (Inst),
    .inst_valid (inst_valid),
    .exec_done  (exec_done),
    .Branch     (Branch),
    .Zero       (Zero),
    .Jump       (Jump),
    .JumpReg    (JumpReg),
    .reg31      (reg31),
    .pc         (pc),
    .fetch_err  (fetch_err)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference next-PC computed with plain arithmetic from the instruction fields.
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] ins,
                                           input logic b, input logic z, input logic j,
                                           input logic jr, input logic [31:0] r31);
    logic [31:0] pc4;
    logic signed [15:0] imm;
    int off;
    pc4 = cur + 32'd4;
    imm = ins[15:0];
    off = int'(imm) * 4;
    if (jr) return r31;
    if (j) return (pc4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
    if (b && z) return pc4 + 32'(off);
    return pc4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic clear_inputs();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    exec_done  = 1'b0;
    Branch     = 1'b0;
    Zero       = 1'b0;
    Jump       = 1'b0;
    JumpReg    = 1'b0;
    reg31      = 32'h0;
  endtask

  // Hold Reset for n cycles, check reset values, release and reach FETCH.
  task automatic apply_reset(input int n);
    Reset = 1'b1;
    repeat (n) tick();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_pc", pc, RST_PC);
    chk("rst_inst", Inst, 32'h0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    Reset = 1'b0;
    tick();
    chk("rel_req", 32'(imem_req), 32'd1);
    chk("rel_addr", imem_addr, RST_PC);
    m_pc   = RST_PC;
    m_inst = 32'h0;
  endtask

  // Wait 'delay' cycles without ack (exec_done noise ignored), then ack with rdata.
  task automatic fetch(input int delay, input logic [31:0] rdata);
    for (int i = 0; i < delay; i++) begin
      chk("wait_req", 32'(imem_req), 32'd1);
      exec_done = 1'($urandom_range(0, 1));
      tick();
    end
    exec_done = 1'b0;
    chk("fetch_req", 32'(imem_req), 32'd1);
    chk("fetch_addr", imem_addr, m_pc);
    chk("fetch_err", 32'(fetch_err), 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    chk("exec_valid", 32'(inst_valid), 32'd1);
    chk("exec_inst", Inst, rdata);
    chk("exec_req", 32'(imem_req), 32'd0);
    m_inst = rdata;
  endtask

  // Idle in EXEC with ignored noise, then complete with the given controls.
  task automatic execute(input int idle, input logic b, input logic z, input logic j,
                         input logic jr, input logic [31:0] r31, output logic err_out);
    logic [31:0] exp;
    for (int i = 0; i < idle; i++) begin
      Branch   = 1'($urandom_range(0, 1));
      Zero     = 1'($urandom_range(0, 1));
      Jump     = 1'($urandom_range(0, 1));
      JumpReg  = 1'($urandom_range(0, 1));
      reg31    = $urandom;
      imem_ack = 1'($urandom_range(0, 1));
      tick();
      chk("exec_hold", 32'(inst_valid), 32'd1);
    end
    imem_ack  = 1'b0;
    Branch    = b;
    Zero      = z;
    Jump      = j;
    JumpReg   = jr;
    reg31     = r31;
    exec_done = 1'b1;
    tick();
    clear_inputs();
    exp     = ref_next(m_pc, m_inst, b, z, j, jr, r31);
    err_out = (exp[1:0] != 2'b00);
    chk("done_valid", 32'(inst_valid), 32'd0);
    if (err_out) begin
      chk("misal_err", 32'(fetch_err), 32'd1);
      chk("misal_req", 32'(imem_req), 32'd0);
      chk("misal_pc", pc, m_pc);
    end else begin
      chk("next_err", 32'(fetch_err), 32'd0);
      chk("next_req", 32'(imem_req), 32'd1);
      chk("next_addr", imem_addr, exp);
      m_pc = exp;
    end
  endtask

  initial begin
    Reset = 1'b1;
    clear_inputs();
    m_pc   = RST_PC;
    m_inst = 32'h0;

    // Basic fetch and sequential advance.
    apply_reset(2);
    fetch(0, 32'h2002_0005);
    execute(0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, err_seen);
    chk("t1_addr4", imem_addr, 32'h4);

    // Taken branch back onto itself, then untaken.
    fetch(1, 32'h0000_0000);
    execute(1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, err_seen);
    fetch(0, 32'h1000_FFFF);
    execute(2, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, err_seen);
    chk("t2_taken", imem_addr, 32'h8);
    fetch(0, 32'h1000_FFFF);
    execute(0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, err_seen);
    chk("t2_untaken", imem_addr, 32'hC);

    // jr to 0x1000_0010, then j with target 0x40 (also asserting a taken branch).
    fetch(0, 32'h0);
    execute(0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1000_0010, err_seen);
    fetch(2, 32'h0800_0040);
    execute(0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, err_seen);
    chk("t3_jump", imem_addr, 32'h1000_0100);

    // Aligned jr, then misaligned jr into a sticky error.
    fetch(0, 32'h0);
    execute(0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_000C, err_seen);
    chk("t4_jr_ok", imem_addr, 32'hC);
    fetch(0, 32'h0);
    execute(0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_000D, err_seen);
    chk("t4_err_flag", 32'(err_seen), 32'd1);
    imem_ack  = 1'b1;
    exec_done = 1'b1;
    repeat (3) tick();
    clear_inputs();
    chk("t4_err_hold", 32'(fetch_err), 32'd1);
    chk("t4_req_hold", 32'(imem_req), 32'd0);
    chk("t4_valid_hold", 32'(inst_valid), 32'd0);

    // Fetch timeout: error appears after TMO ack-less cycles.
    apply_reset(1);
    for (int k = 1; k < TMO; k++) begin
      tick();
      chk("t5_no_err_yet", 32'(fetch_err), 32'd0);
      chk("t5_req_held", 32'(imem_req), 32'd1);
    end
    tick();
    chk("t5_timeout_err", 32'(fetch_err), 32'd1);
    chk("t5_timeout_req", 32'(imem_req), 32'd0);

    // Ack in the last allowed cycle completes normally.
    apply_reset(2);
    fetch(TMO - 1, 32'hCAFE_0001);
    execute(0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, err_seen);
    chk("t5_late_ack", imem_addr, 32'h4);

    // Reset mid-FETCH and mid-EXEC.
    apply_reset(1);
    fetch(0, 32'h0);
    execute(0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, err_seen);
    fetch(0, 32'h1234_5678);
    apply_reset(1);

    // PC wrap from FFFF_FFFC to 0.
    fetch(0, 32'h0);
    execute(0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, err_seen);
    fetch(1, 32'h0);
    execute(0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, err_seen);
    chk("t6_wrap", imem_addr, 32'h0);

    // Randomized transactions against the reference model.
    for (int n = 0; n < 60; n++) begin
      logic rb, rz, rj, rjr;
      logic [31:0] r31;
      rb  = 1'($urandom_range(0, 1));
      rz  = 1'($urandom_range(0, 1));
      rj  = ($urandom_range(0, 3) == 0);
      rjr = ($urandom_range(0, 5) == 0);
      r31 = $urandom;
      if ($urandom_range(0, 3) != 0) r31 = r31 & 32'hFFFF_FFFC;
      fetch(int'($urandom_range(0, TMO - 1)), $urandom);
      execute(int'($urandom_range(0, 3)), rb, rz, rj, rjr, r31, err_seen);
      if (err_seen) apply_reset(int'($urandom_range(1, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
